// File: rtl/instruction_decoder_pkg.sv
// Shared constants for the fetch/decode stage: registers, addressing modes,
// instruction formats, sequencer states and opcode groups.
package instruction_decoder_pkg;

  // Register numbers; R2/R3 double as the constant generators.
  localparam logic [3:0] R0  = 4'd0;
  localparam logic [3:0] R1  = 4'd1;
  localparam logic [3:0] R2  = 4'd2;
  localparam logic [3:0] R3  = 4'd3;
  localparam logic [3:0] R4  = 4'd4;
  localparam logic [3:0] R5  = 4'd5;
  localparam logic [3:0] R6  = 4'd6;
  localparam logic [3:0] R7  = 4'd7;
  localparam logic [3:0] R8  = 4'd8;
  localparam logic [3:0] R9  = 4'd9;
  localparam logic [3:0] R10 = 4'd10;
  localparam logic [3:0] R11 = 4'd11;
  localparam logic [3:0] R12 = 4'd12;
  localparam logic [3:0] R13 = 4'd13;
  localparam logic [3:0] R14 = 4'd14;
  localparam logic [3:0] R15 = 4'd15;
  localparam logic [3:0] CG1 = R2;
  localparam logic [3:0] CG2 = R3;

  // Source addressing modes (As); destination uses only bit 0 (Ad).
  localparam logic [1:0] AS_REG = 2'b00;  // Rn
  localparam logic [1:0] AS_IDX = 2'b01;  // x(Rn), &abs
  localparam logic [1:0] AS_IND = 2'b10;  // @Rn
  localparam logic [1:0] AS_INC = 2'b11;  // @Rn+, #imm

  // Instruction format encodings on fmt.
  localparam logic [1:0] FMT_I   = 2'b00;
  localparam logic [1:0] FMT_II  = 2'b01;
  localparam logic [1:0] FMT_JMP = 2'b10;
  localparam logic [1:0] FMT_ILL = 2'b11;

  // Sequencer states.
  localparam logic [1:0] ST_FETCH_IW  = 2'd0;
  localparam logic [1:0] ST_FETCH_SRC = 2'd1;
  localparam logic [1:0] ST_FETCH_DST = 2'd2;
  localparam logic [1:0] ST_ISSUE     = 2'd3;

  // Opcode groups: format I opcodes live in IW[15:12], format II in IW[15:7].
  localparam logic [3:0] OP_MOV   = 4'h4;
  localparam logic [3:0] OP_ADD   = 4'h5;
  localparam logic [3:0] OP_AND   = 4'hF;
  localparam logic [5:0] OP_FMT2  = 6'b000100;
  localparam logic [8:0] OP_RRC   = 9'b000100_000;
  localparam logic [2:0] OP_JUMP  = 3'b001;

endpackage

// File: rtl/instruction_decoder_iw_field_decode.sv
// Combinational split of an instruction word into its format fields and the
// number of extension words it needs.
module instruction_decoder_iw_field_decode
  import instruction_decoder_pkg::*;
(
  input  logic [15:0] iw,
  output logic [3:0]  src_a,
  output logic [1:0]  as_mode,
  output logic [3:0]  dst_a,
  output logic        ad,
  output logic        bw,
  output logic [1:0]  fmt,
  output logic        need_src,
  output logic        need_dst
);

  // Field extraction by format, then extension-word requirements.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves one unassigned (no latch).
    src_a   = R0;
    as_mode = AS_REG;
    dst_a   = R0;
    ad      = 1'b0;
    bw      = 1'b0;
    fmt     = FMT_ILL;
    if (iw[15:12] >= OP_MOV) begin
      fmt     = FMT_I;
      src_a   = iw[11:8];
      ad      = iw[7];
      bw      = iw[6];
      as_mode = iw[5:4];
      dst_a   = iw[3:0];
    end else if (iw[15:10] == OP_FMT2) begin
      fmt     = FMT_II;
      src_a   = iw[3:0];
      dst_a   = iw[3:0];
      as_mode = iw[5:4];
      bw      = iw[6];
    end else if (iw[15:13] == OP_JUMP) begin
      fmt = FMT_JMP;
    end
    // Indexed/absolute needs a word unless it is the CG2 constant; #imm is @PC+.
    need_src = ((fmt == FMT_I) || (fmt == FMT_II)) &&
               (((as_mode == AS_IDX) && (src_a != CG2)) ||
                ((as_mode == AS_INC) && (src_a == R0)));
    need_dst = (fmt == FMT_I) && ad;
  end

endmodule

// File: rtl/instruction_decoder.sv
// Fetch/decode sequencer: latches the instruction word and its 0-2 extension
// words from the memory bus, then holds them for execute until consumed.
module instruction_decoder
  import instruction_decoder_pkg::*;
#(
  parameter logic [15:0] RESET_IW = 16'h4303
) (
  input  logic        MCLK,
  input  logic        reset,
  input  logic        flush,
  input  logic [15:0] MDB_in,
  input  logic        mem_valid,
  output logic        fetch_req,
  output logic        pc_inc,
  output logic [15:0] IW,
  output logic [3:0]  srcA,
  output logic [1:0]  As,
  output logic [3:0]  dstA,
  output logic        Ad,
  output logic        BW,
  output logic [1:0]  fmt,
  output logic [15:0] srcExt,
  output logic [15:0] dstExt,
  output logic        dec_valid,
  input  logic        exec_ready
);

  logic [1:0] state;
  logic       need_dst_q;

  logic [3:0] d_src_a;
  logic [1:0] d_as;
  logic [3:0] d_dst_a;
  logic       d_ad;
  logic       d_bw;
  logic [1:0] d_fmt;
  logic       d_need_src;
  logic       d_need_dst;

  // Decode straight off the bus so fields latch together with IW.
  instruction_decoder_iw_field_decode u_decode (
    .iw       (MDB_in),
    .src_a    (d_src_a),
    .as_mode  (d_as),
    .dst_a    (d_dst_a),
    .ad       (d_ad),
    .bw       (d_bw),
    .fmt      (d_fmt),
    .need_src (d_need_src),
    .need_dst (d_need_dst)
  );

  // A word is accepted whenever we are fetching and the bus delivers; flush discards it.
  assign fetch_req = (state != ST_ISSUE);
  assign pc_inc    = fetch_req && mem_valid && !flush && !reset;
  assign dec_valid = (state == ST_ISSUE) && !flush;

  // Sequencer and field registers; flush only redirects the state.
  always_ff @(posedge MCLK or posedge reset) begin
    if (reset) begin
      state      <= ST_FETCH_IW;
      need_dst_q <= 1'b0;
      IW         <= RESET_IW;
      srcA       <= R0;
      As         <= AS_REG;
      dstA       <= R0;
      Ad         <= 1'b0;
      BW         <= 1'b0;
      fmt        <= FMT_I;
      srcExt     <= 16'h0000;
      dstExt     <= 16'h0000;
    end else if (flush) begin
      state <= ST_FETCH_IW;
    end else begin
      // NOTE: non-blocking assignments keep every register updating from pre-edge values.
      case (state)
        ST_FETCH_IW: begin
          if (mem_valid) begin
            IW         <= MDB_in;
            srcA       <= d_src_a;
            As         <= d_as;
            dstA       <= d_dst_a;
            Ad         <= d_ad;
            BW         <= d_bw;
            fmt        <= d_fmt;
            need_dst_q <= d_need_dst;
            srcExt     <= 16'h0000;
            dstExt     <= 16'h0000;
            if (d_need_src)      state <= ST_FETCH_SRC;
            else if (d_need_dst) state <= ST_FETCH_DST;
            else                 state <= ST_ISSUE;
          end
        end
        ST_FETCH_SRC: begin
          if (mem_valid) begin
            srcExt <= MDB_in;
            state  <= need_dst_q ? ST_FETCH_DST : ST_ISSUE;
          end
        end
        ST_FETCH_DST: begin
          if (mem_valid) begin
            dstExt <= MDB_in;
            state  <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (exec_ready) state <= ST_FETCH_IW;
        end
        default: state <= ST_FETCH_IW;
      endcase
    end
  end

endmodule

// File: doc/instruction_decoder.md
Name: instruction_decoder

Overview:
- Fetch/decode stage directly upstream of ConstantGenerator.
- Accepts the instruction word and any extension words from the memory data bus.
- Extracts the format fields, holds them stable and issues them to the operand/CG/execute stage.
- Sequences 0–2 extension words per the MSP430 addressing rules and handshakes with execute.

Parameters:
- RESET_IW, 16'h4303, IW value held while idle/after reset (NOP = MOV #0,R3).

Ports:
- MCLK  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous abort; discard the current instruction and refetch.
- MDB_in  in  16  memory data bus word.
- mem_valid  in  1  MDB_in holds the requested word this cycle.
- fetch_req  out  1  word requested at PC.
- pc_inc  out  1  one-cycle pulse per word accepted; PC += 2.
- IW  out  16  latched instruction word.
- srcA  out  4  source register.
- As  out  2  source addressing mode.
- dstA  out  4  destination register.
- Ad  out  1  destination addressing mode.
- BW  out  1  byte/word flag.
- fmt  out  2  00 = format I, 01 = format II, 10 = jump, 11 = illegal.
- srcExt  out  16  source extension word.
- dstExt  out  16  destination extension word.
- dec_valid  out  1  outputs valid for execute.
- exec_ready  in  1  execute consumes when dec_valid && exec_ready.

Behaviour:
- Reset values (async): state = FETCH_IW; IW = RESET_IW; srcA, As, dstA, Ad, BW = 0; fmt = 00; srcExt = dstExt = 0; dec_valid = 0; pc_inc = 0. fetch_req = 1 after reset release.
- States: FETCH_IW, FETCH_SRC, FETCH_DST, ISSUE.
- fetch_req = 1 in every FETCH_* state. pc_inc = fetch_req && mem_valid.
- FETCH_IW, on mem_valid:
  - Latch IW and all decoded fields from MDB_in.
  - Next state: FETCH_SRC if needSrc, else FETCH_DST if needDst, else ISSUE.
- Field decode:
  - IW[15:12] >= 4 → format I: srcA = IW[11:8], Ad = IW[7], BW = IW[6], As = IW[5:4], dstA = IW[3:0].
  - IW[15:10] = 000100 → format II: srcA = dstA = IW[3:0], As = IW[5:4], BW = IW[6], Ad = 0.
  - IW[15:13] = 001 → jump: srcA, As, dstA, Ad, BW = 0.
  - Anything else → illegal: fields 0, no extension words.
- needSrc (formats I and II only):
  - (As = 01 && srcA != R3), or (As = 11 && srcA = R0).
  - R3 with As = 01 and all CG constant forms take no extension word.
  - R2 with As = 01 (absolute) takes one.
- needDst: format I && Ad = 1.
- FETCH_SRC, on mem_valid: srcExt ← MDB_in; next FETCH_DST if needDst, else ISSUE.
- FETCH_DST, on mem_valid: dstExt ← MDB_in; next ISSUE.
- Extension registers not used by the current instruction are cleared to 0 when IW is latched.
- No mem_valid → hold state; no pc_inc.
- ISSUE:
  - dec_valid = 1 and all outputs stable.
  - On exec_ready: next FETCH_IW, dec_valid falls the following cycle.
  - No back-to-back overlap: the next IW fetch begins the cycle after consume.
- Latency: IW accepted at cycle N with k extension words at consecutive cycles → dec_valid high at N+1+k.
- flush:
  - Has priority over all transitions in every state: next state FETCH_IW, dec_valid = 0, pc_inc suppressed that cycle.
  - Field registers are held, not cleared.
  - flush together with mem_valid: the word is discarded.
- reset mid-operation: immediate async return to reset values; partially fetched extension words are lost.

Decomposition:
- Shared package/include (MACROS):
  - Register constants R0–R15 with CG1 = R2 and CG2 = R3.
  - Addressing mode constants.
  - fmt encodings.
  - State encodings.
  - Opcode constants (MOV, RRC, ...).
- Sub-module: combinational iw_field_decode (IW → srcA, As, dstA, Ad, BW, fmt, needSrc, needDst).
- The sequencer and registers stay in instruction_decoder.

Test Plan:
- 0x4405 (MOV R4,R5), mem_valid every cycle → dec_valid at N+1; srcA = 4, As = 0, dstA = 5, Ad = 0, fmt = 00, one pc_inc.
- 0x4035, 0x0005 (MOV #5,R5) → srcExt = 0x0005, dstExt = 0, dec_valid at N+2, two pc_inc pulses.
- 0x4295, 0x0200, 0x0004 (MOV &0x0200,4(R5)) → srcA = 2, As = 01, Ad = 1, srcExt = 0x0200, dstExt = 0x0004, dec_valid at N+3.
- 0x4315 (MOV #1,R5 via CG2) → no extension fetch, dec_valid at N+1.
- 0x1005 (RRC R5) → fmt = 01, srcA = dstA = 5.
- 0x3FFF → fmt = 10.
- 0x0000 → fmt = 11.
- All three of 0x4315, 0x1005 and 0x3FFF issue at N+1.
- Handshake and abort:
  - 0x4035 with exec_ready low for 5 cycles → outputs stable, dec_valid held, no fetch_req.
  - flush asserted in FETCH_SRC → FETCH_IW next cycle, no pc_inc that cycle.
  - reset asserted mid-FETCH_DST → all outputs reset asynchronously.
